// File: rtl/dog_extrema_detect.sv
`default_nettype none
// ============================================================================
// Module : dog_extrema_detect
// Desc   : Raster-stream 3x3 local-maximum keypoint detector for DoG magnitudes.
// Rev    : 1.0  initial release
// ============================================================================
module dog_extrema_detect #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int THRESH = 8
) (
    input  logic        clk,
    input  logic        irst_n,
    input  logic        isof,
    input  logic [8:0]  idata,
    output logic        okey_valid,
    output logic [9:0]  okey_x,
    output logic [9:0]  okey_y,
    output logic [7:0]  okey_mag,
    output logic [15:0] ocount,
    output logic        odone
);
    localparam int         C_AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [9:0] C_LAST_X = 10'(IMG_W - 1);
    localparam logic [9:0] C_LAST_Y = 10'(IMG_H - 1);
    localparam logic [7:0] C_THRESH = 8'(THRESH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [7:0]  r_top [3];
    logic [7:0]  r_mid [3];
    logic [7:0]  r_bot [3];
    logic [7:0]  r_lb1 [IMG_W];
    logic [7:0]  r_lb2 [IMG_W];

    logic             w_valid;
    logic             w_start;
    logic             w_accept;
    logic [9:0]       w_px;
    logic [9:0]       w_py;
    logic [C_AW-1:0]  w_col;
    logic [7:0]       w_pix;
    logic [7:0]       w_row1;
    logic [7:0]       w_row2;
    logic [7:0]       w_centre;
    logic             w_peak;
    logic             w_hit;
    logic             w_last;

    assign w_valid  = idata[8];
    assign w_pix    = idata[7:0];
    assign w_start  = w_valid & isof;
    assign w_accept = w_valid & (isof | (r_state == S_ACTIVE));

    // A start-of-frame pixel is always (0,0), whatever the counters hold.
    assign w_px   = isof ? 10'd0 : r_x;
    assign w_py   = isof ? 10'd0 : r_y;
    assign w_col  = w_px[C_AW-1:0];
    assign w_row1 = r_lb1[w_col];
    assign w_row2 = r_lb2[w_col];
    assign w_last = w_accept & (w_px == C_LAST_X) & (w_py == C_LAST_Y);

    // Centre is the middle of the previous column; the incoming column is the right edge.
    assign w_centre = r_mid[2];
    assign w_peak   = (w_centre > C_THRESH)
                    & (w_centre > r_top[1]) & (w_centre > r_mid[1]) & (w_centre > r_bot[1])
                    & (w_centre > r_top[2]) & (w_centre > r_bot[2])
                    & (w_centre > w_row2)   & (w_centre > w_row1)   & (w_centre > w_pix);
    assign w_hit    = w_accept & (w_px >= 10'd2) & (w_py >= 10'd2) & w_peak;

    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_start)     w_state_nxt = S_ACTIVE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_start) w_state_nxt = S_ACTIVE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            r_x <= 10'd0;
            r_y <= 10'd0;
            for (int i = 0; i < 3; i++) begin
                r_top[i] <= 8'd0;
                r_mid[i] <= 8'd0;
                r_bot[i] <= 8'd0;
            end
        end else if (w_accept) begin
            if (w_px == C_LAST_X) begin
                r_x <= 10'd0;
                r_y <= (w_py == C_LAST_Y) ? 10'd0 : w_py + 10'd1;
            end else begin
                r_x <= w_px + 10'd1;
                r_y <= w_py;
            end
            r_top[0] <= r_top[1];
            r_top[1] <= r_top[2];
            r_top[2] <= w_row2;
            r_mid[0] <= r_mid[1];
            r_mid[1] <= r_mid[2];
            r_mid[2] <= w_row1;
            r_bot[0] <= r_bot[1];
            r_bot[1] <= r_bot[2];
            r_bot[2] <= w_pix;
        end
    end

    // Line buffers cascade: row y-1 moves into the y-2 buffer as row y arrives.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_col] <= w_pix;
            r_lb2[w_col] <= w_row1;
        end
    end

    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            okey_valid <= 1'b0;
            okey_x     <= 10'd0;
            okey_y     <= 10'd0;
            okey_mag   <= 8'd0;
            ocount     <= 16'd0;
            odone      <= 1'b0;
        end else begin
            okey_valid <= w_hit;
            odone      <= w_last;
            if (w_hit) begin
                okey_x   <= w_px - 10'd1;
                okey_y   <= w_py - 10'd1;
                okey_mag <= w_centre;
            end
            if (w_start) begin
                ocount <= 16'd0;
            end else if (w_hit && (ocount != 16'hFFFF)) begin
                ocount <= ocount + 16'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dog_extrema_detect.sv
`default_nettype none
// ============================================================================
// Module : tb_dog_extrema_detect
// Desc   : Self-checking bench: directed and random frames against a 2-D peak model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dog_extrema_detect;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int TH = 8;

    logic        clk;
    logic        irst_n;
    logic        isof;
    logic [8:0]  idata;
    logic        okey_valid;
    logic [9:0]  okey_x;
    logic [9:0]  okey_y;
    logic [7:0]  okey_mag;
    logic [15:0] ocount;
    logic        odone;

    dog_extrema_detect #(
        .IMG_W  (W),
        .IMG_H  (H),
        .THRESH (TH)
    ) u_dut (
        .clk        (clk),
        .irst_n     (irst_n),
        .isof       (isof),
        .idata      (idata),
        .okey_valid (okey_valid),
        .okey_x     (okey_x),
        .okey_y     (okey_y),
        .okey_mag   (okey_mag),
        .ocount     (ocount),
        .odone      (odone)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [7:0] img     [H][W];
    int         acc_cyc [H][W];
    int         kx_q[$];
    int         ky_q[$];
    int         km_q[$];
    int         kc_q[$];
    int         dq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (okey_valid) begin
            kx_q.push_back(int'(okey_x));
            ky_q.push_back(int'(okey_y));
            km_q.push_back(int'(okey_mag));
            kc_q.push_back(cyc);
        end
        if (odone) dq.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_events();
        kx_q.delete();
        ky_q.delete();
        km_q.delete();
        kc_q.delete();
        dq.delete();
    endtask

    task automatic clear_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = 8'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            isof  = 1'b0;
            idata = 9'h000;
        end
    endtask

    task automatic drive_pixel(input bit sof, input logic [7:0] v, input int gaps, output int c);
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            isof  = 1'b0;
            idata = 9'h000;
        end
        @(negedge clk);
        isof  = sof;
        idata = {1'b1, v};
        c     = cyc;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(okey_valid), 0);
        check({tag, "_x"},     32'(okey_x),     0);
        check({tag, "_y"},     32'(okey_y),     0);
        check({tag, "_mag"},   32'(okey_mag),   0);
        check({tag, "_count"}, 32'(ocount),     0);
        check({tag, "_done"},  32'(odone),      0);
    endtask

    // Streams img as one frame and compares against a direct 2-D local-maximum scan.
    task automatic run_frame(input string tag, input int gapmax);
        int ex[$];
        int ey[$];
        int em[$];
        int c;
        int n;
        bit ok;
        clear_events();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                drive_pixel((x == 0) && (y == 0), img[y][x],
                            (gapmax > 0) ? int'($urandom_range(1, gapmax)) : 0, c);
                acc_cyc[y][x] = c;
                if ((x == 0) && (y == 0)) begin
                    @(negedge clk);
                    isof  = 1'b0;
                    idata = 9'h000;
                    check({tag, "_ocount_clear"}, 32'(ocount), 0);
                end
            end
        end
        idle(4);

        for (int cy = 1; cy < H - 1; cy++) begin
            for (int cx = 1; cx < W - 1; cx++) begin
                ok = (int'(img[cy][cx]) > TH);
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (!(dy == 0 && dx == 0) && img[cy+dy][cx+dx] >= img[cy][cx])
                            ok = 1'b0;
                if (ok) begin
                    ex.push_back(cx);
                    ey.push_back(cy);
                    em.push_back(int'(img[cy][cx]));
                end
            end
        end

        check({tag, "_nkeys"}, 32'(kx_q.size()), 32'(ex.size()));
        n = (kx_q.size() < ex.size()) ? kx_q.size() : ex.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_key_x"},   32'(kx_q[i]), 32'(ex[i]));
            check({tag, "_key_y"},   32'(ky_q[i]), 32'(ey[i]));
            check({tag, "_key_mag"}, 32'(km_q[i]), 32'(em[i]));
            check({tag, "_key_cyc"}, 32'(kc_q[i]), 32'(acc_cyc[ey[i]+1][ex[i]+1] + 1));
        end
        check({tag, "_ocount"}, 32'(ocount), 32'(ex.size()));
        check({tag, "_ndone"},  32'(dq.size()), 1);
        if (dq.size() > 0)
            check({tag, "_done_cyc"}, 32'(dq[0]), 32'(acc_cyc[H-1][W-1] + 1));
    endtask

    initial begin
        int c;
        int kn;
        irst_n = 1'b0;
        isof   = 1'b0;
        idata  = 9'h000;
        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        irst_n = 1'b1;

        // Valid pixels without a start-of-frame must be ignored.
        clear_events();
        for (int i = 0; i < 12; i++) drive_pixel(1'b0, 8'd200, 0, c);
        idle(3);
        check_zero_outputs("pre_sof");
        check("pre_sof_events", 32'(kx_q.size() + dq.size()), 0);

        clear_img(); img[2][3] = 8'd50;
        run_frame("peak50", 0);
        clear_img(); img[2][3] = 8'd50; img[2][4] = 8'd50;
        run_frame("tie", 0);
        clear_img(); img[2][3] = 8'd8;
        run_frame("peak8", 0);
        clear_img(); img[2][3] = 8'd9;
        run_frame("peak9", 0);
        clear_img(); img[2][0] = 8'd60; img[3][7] = 8'd60;
        run_frame("border", 0);
        clear_img(); img[2][3] = 8'd50;
        run_frame("gaps", 3);

        // Aborted frame of zeros, restarted by a fresh start-of-frame.
        clear_events();
        for (int i = 0; i < 20; i++) drive_pixel(i == 0, 8'd0, 0, c);
        clear_img(); img[2][3] = 8'd50;
        run_frame("restart", 0);

        for (int f = 0; f < 6; f++) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    img[y][x] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(9, 40))
                                                            : 8'($urandom_range(0, 12));
            run_frame("rand", (f % 2 == 1) ? 3 : 0);
        end

        // Reset in the middle of a frame after one keypoint has been reported.
        clear_img(); img[2][3] = 8'd50;
        clear_events();
        for (int i = 0; i < 30; i++) drive_pixel(i == 0, img[i / W][i % W], 0, c);
        @(negedge clk);
        check("mid_keys", 32'(kx_q.size()), 1);
        kn     = kx_q.size();
        irst_n = 1'b0;
        isof   = 1'b0;
        idata  = 9'h000;
        #1;
        check_zero_outputs("mid_reset");
        repeat (3) @(negedge clk);
        irst_n = 1'b1;
        for (int i = 30; i < W * H; i++) drive_pixel(1'b0, img[i / W][i % W], 0, c);
        idle(4);
        check("post_rst_done", 32'(dq.size()), 0);
        check("post_rst_keys", 32'(kx_q.size()), 32'(kn));
        check_zero_outputs("post_rst");

        clear_img(); img[3][5] = 8'd77;
        run_frame("recover", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
